// File: rtl/seq_mult_if.sv
// Handshake and data bundle for seq_mult.
// master: operand source, slave: the multiplier.
// With SEQ_MULT_SIGNED_EN defined the bundle also carries i_signed.
interface seq_mult_if #(
   parameter int unsigned WIDTH = 8
);
   logic                 i_valid;
   logic [WIDTH-1:0]     i_arg1;
   logic [WIDTH-1:0]     i_arg2;
`ifdef SEQ_MULT_SIGNED_EN
   logic                 i_signed;
`endif
   logic                 o_ready;
   logic                 o_busy;
   logic                 o_valid;
   logic [2*WIDTH-1:0]   o_result;

   modport master (
`ifdef SEQ_MULT_SIGNED_EN
      output i_signed,
`endif
      output i_valid, i_arg1, i_arg2,
      input  o_ready, o_busy, o_valid, o_result
   );

   modport slave (
`ifdef SEQ_MULT_SIGNED_EN
      input  i_signed,
`endif
      input  i_valid, i_arg1, i_arg2,
      output o_ready, o_busy, o_valid, o_result
   );
endinterface

// File: rtl/seq_mult.sv
// Iterative shift-and-add multiplier: one multiplier bit per cycle, WIDTH cycles per product.
// Optional macro SEQ_MULT_SIGNED_EN adds two's-complement operation selected by i_signed.
module seq_mult #(
   parameter int unsigned WIDTH = 8
) (
   input  logic       i_clk,
   input  logic       i_rst,
   seq_mult_if.slave  bus
);
   localparam int unsigned ResW = 2 * WIDTH;
   localparam int unsigned CntW = $clog2(WIDTH);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StRun  = 2'd1;
   localparam logic [1:0] StDone = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [ResW-1:0]  mcand_q, mcand_d;
   logic [ResW-1:0]  acc_q, acc_d;
   logic [ResW-1:0]  result_q, result_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic [ResW-1:0]  acc_sum;
   logic [ResW-1:0]  final_val;
   logic [WIDTH-1:0] arg1_mag, arg2_mag;
   logic             accept;
`ifdef SEQ_MULT_SIGNED_EN
   logic             sign_q, sign_d;
`endif

   assign accept = bus.i_valid && bus.o_ready;

   // Operand conditioning: magnitudes for signed mode, plain operands otherwise.
   always_comb begin
`ifdef SEQ_MULT_SIGNED_EN
      arg1_mag = (bus.i_signed && bus.i_arg1[WIDTH-1]) ? (~bus.i_arg1 + WIDTH'(1)) : bus.i_arg1;
      arg2_mag = (bus.i_signed && bus.i_arg2[WIDTH-1]) ? (~bus.i_arg2 + WIDTH'(1)) : bus.i_arg2;
`else
      arg1_mag = bus.i_arg1;
      arg2_mag = bus.i_arg2;
`endif
   end

   // Partial-product add for this cycle and the value committed on completion.
   always_comb begin
      acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
`ifdef SEQ_MULT_SIGNED_EN
      // Negation is applied on the completion edge so latency stays WIDTH cycles.
      final_val = sign_q ? (~acc_sum + ResW'(1)) : acc_sum;
`else
      final_val = acc_sum;
`endif
   end

   // Next-state: FSM, shift/add datapath and operand load on accept.
   always_comb begin
      state_d  = state_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      result_d = result_q;
`ifdef SEQ_MULT_SIGNED_EN
      sign_d   = sign_q;
`endif
      unique case (state_q)
         StIdle: state_d = StIdle;
         StRun: begin
            acc_d    = acc_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - CntW'(1);
            if (cnt_q == '0) begin
               result_d = final_val;
               state_d  = StDone;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
      // Accept is only possible in IDLE/DONE, so this never disturbs a RUN in flight.
      if (accept) begin
         mcand_d  = {{WIDTH{1'b0}}, arg1_mag};
         mplier_d = arg2_mag;
         acc_d    = '0;
         cnt_d    = CntW'(WIDTH - 1);
         state_d  = StRun;
`ifdef SEQ_MULT_SIGNED_EN
         sign_d   = bus.i_signed && (bus.i_arg1[WIDTH-1] ^ bus.i_arg2[WIDTH-1]);
`endif
      end
   end

   // State registers with synchronous reset; reset discards any operation in flight.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q  <= StIdle;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         result_q <= '0;
`ifdef SEQ_MULT_SIGNED_EN
         sign_q   <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
`ifdef SEQ_MULT_SIGNED_EN
         sign_q   <= sign_d;
`endif
      end
   end

   assign bus.o_ready  = (state_q == StIdle) || (state_q == StDone);
   assign bus.o_busy   = (state_q == StRun);
   assign bus.o_valid  = (state_q == StDone);
   assign bus.o_result = result_q;
endmodule

// File: tb/tb_seq_mult.sv
// Self-checking bench for seq_mult (WIDTH=8): directed cases plus random products against
// an arithmetic reference model.
module tb_seq_mult;
   localparam int unsigned W = 8;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_errs;

   seq_mult_if #(.WIDTH(W)) bus ();

   seq_mult #(.WIDTH(W)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s: got=%0d (0x%0h) expected=%0d (0x%0h)", tag, got, got, exp, exp);
      end
   endtask

   // Reference product: plain integer arithmetic on the operands' numeric values.
   function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic s);
      longint sa, sb;
      sa = longint'(a);
      sb = longint'(b);
      if (s && a[W-1]) sa = sa - (longint'(1) << W);
      if (s && b[W-1]) sb = sb - (longint'(1) << W);
      return (2*W)'(sa * sb);
   endfunction

   // Advance one clock; sample point is 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s);
      bus.i_valid = v;
      bus.i_arg1  = a;
      bus.i_arg2  = b;
`ifdef SEQ_MULT_SIGNED_EN
      bus.i_signed = s;
`else
      if (s) $display("note: signed request in unsigned build treated as unsigned");
`endif
   endtask

   task automatic wait_ready(input string tag);
      int n;
      n = 0;
      while (!bus.o_ready && n < 40) begin
         step();
         n++;
      end
      if (!bus.o_ready) check({tag, "_ready_timeout"}, 32'(n), 32'(40 + 1));
   endtask

   // Wait for o_valid with a cycle budget; optionally scramble operand inputs meanwhile.
   task automatic wait_valid(input logic scramble, output int lat, output int busy_cnt);
      lat = 0;
      busy_cnt = 0;
      while (!bus.o_valid && lat < 40) begin
         if (bus.o_busy) busy_cnt++;
         if (scramble) begin
            bus.i_arg1 = W'($urandom);
            bus.i_arg2 = W'($urandom);
         end
         step();
         lat++;
      end
   endtask

   // One complete operation with latency, busy-length, strobe and product checks.
   task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s);
      int lat, busy_cnt;
      wait_ready(tag);
      drive(1'b1, a, b, s);
      step();
      bus.i_valid = 1'b0;
      wait_valid(1'b1, lat, busy_cnt);
      check({tag, "_latency"}, 32'(lat), 32'(W));
      check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(W));
      check({tag, "_result"}, 32'(bus.o_result), 32'(ref_prod(a, b, s)));
      check({tag, "_busy_at_done"}, 32'(bus.o_busy), 32'(0));
   endtask

   initial begin
      int lat, busy_cnt, vcount;
      logic [W-1:0] ra, rb;
      logic rs;
      n_checks = 0;
      n_errs   = 0;
      rst = 1'b1;
      drive(1'b0, '0, '0, 1'b0);

      // Reset held three cycles
      repeat (3) step();
      rst = 1'b0;
      check("rst_ready", 32'(bus.o_ready), 32'(1));
      check("rst_busy", 32'(bus.o_busy), 32'(0));
      check("rst_valid", 32'(bus.o_valid), 32'(0));
      check("rst_result", 32'(bus.o_result), 32'(0));
      step();

      // 13 x 11, strobe one cycle, result holds
      do_op("m13x11", 8'd13, 8'd11, 1'b0);
      check("m13x11_abs", 32'(bus.o_result), 32'd143);
      step();
      check("m13x11_strobe_once", 32'(bus.o_valid), 32'(0));
      repeat (9) step();
      check("m13x11_hold", 32'(bus.o_result), 32'd143);
      check("m13x11_hold_valid", 32'(bus.o_valid), 32'(0));

      // Extremes
      do_op("m255x255", 8'd255, 8'd255, 1'b0);
      check("m255x255_abs", 32'(bus.o_result), 32'h0000_FE01);
      do_op("m0x200", 8'd0, 8'd200, 1'b0);

      // Request during RUN ignored; request in DONE accepted with no idle gap
      wait_ready("ign");
      drive(1'b1, 8'd7, 8'd9, 1'b0);
      step();
      bus.i_valid = 1'b0;
      step();
      step();
      drive(1'b1, 8'd100, 8'd100, 1'b0);
      wait_valid(1'b0, lat, busy_cnt);
      check("ign_latency", 32'(lat), 32'(W - 2));
      check("ign_result", 32'(bus.o_result), 32'd63);
      check("ign_ready_done", 32'(bus.o_ready), 32'(1));
      step();
      bus.i_valid = 1'b0;
      check("b2b_busy_no_gap", 32'(bus.o_busy), 32'(1));
      wait_valid(1'b1, lat, busy_cnt);
      check("b2b_latency", 32'(lat), 32'(W));
      check("b2b_result", 32'(bus.o_result), 32'd10000);

      // Reset mid-RUN discards the operation
      step();
      wait_ready("rst_mid");
      drive(1'b1, 8'd200, 8'd3, 1'b0);
      step();
      bus.i_valid = 1'b0;
      repeat (3) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("midrst_ready", 32'(bus.o_ready), 32'(1));
      check("midrst_busy", 32'(bus.o_busy), 32'(0));
      check("midrst_result", 32'(bus.o_result), 32'(0));
      vcount = 0;
      for (int i = 0; i < 20; i++) begin
         if (bus.o_valid) vcount++;
         step();
      end
      check("midrst_no_valid", 32'(vcount), 32'(0));
      check("midrst_result_after", 32'(bus.o_result), 32'(0));

      // Reset has priority over a simultaneous request
      drive(1'b1, 8'd5, 8'd5, 1'b0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      bus.i_valid = 1'b0;
      check("rst_prio_busy", 32'(bus.o_busy), 32'(0));

`ifdef SEQ_MULT_SIGNED_EN
      do_op("s_m3x5", 8'hFD, 8'd5, 1'b1);
      check("s_m3x5_abs", 32'(bus.o_result), 32'h0000_FFF1);
      do_op("s_m128sq", 8'h80, 8'h80, 1'b1);
      check("s_m128sq_abs", 32'(bus.o_result), 32'h0000_4000);
      do_op("u_fdx5", 8'hFD, 8'd5, 1'b0);
      check("u_fdx5_abs", 32'(bus.o_result), 32'd1265);
`endif

      // Random products
      for (int i = 0; i < 24; i++) begin
         ra = W'($urandom);
         rb = W'($urandom);
`ifdef SEQ_MULT_SIGNED_EN
         rs = 1'($urandom);
`else
         rs = 1'b0;
`endif
         do_op($sformatf("rnd%0d", i), ra, rb, rs);
         if ($urandom_range(0, 1) == 0) step();
      end

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

   // Global time limit so the bench can never hang.
   initial begin
      #200000;
      $display("FAIL timeout: simulation time limit reached");
      $fatal(1, "time limit");
   end
endmodule
